mem_access_unit: RTL
====================

# mem_access_unit

MEM-stage load/store initiator for the 5-stage pipeline. Accepts one load or store request at a time from the pipeline over a valid/ready handshake and drives the word-addressed data memory port: combinational read, synchronous write, one 32-bit word per address. Byte and halfword stores become read-modify-write sequences, because the memory has no byte enables. Loads are extracted little-endian and zero- or sign-extended.

## Interface
- DEPTH_WORDS, 1024, data memory depth in words; word index width IDX_W = $clog2(DEPTH_WORDS).
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- req_valid  in  1  request present; held stable with all req_* fields until accepted.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = reserved.
- req_signed  in  1  loads: sign-extend (1) or zero-extend (0).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  access rejected; no memory write occurred.
- mem_wr_en  out  1  memory write enable.
- mem_addr  out  32  word index {zeros, req_addr[IDX_W+1:2]}.
- mem_wdata  out  32  memory write word.
- mem_rdata  in  32  memory read word, combinational from mem_addr.

## Operation
- States: IDLE, RD, RMW_RD, WR, RESP.
- IDLE: req_ready = 1. When req_valid is high, latch all request fields and mem_addr, then branch:
  - error → RESP with err;
  - load → RD;
  - word store → WR with mem_wdata = req_wdata;
  - byte/half store → RMW_RD.
- RD: capture mem_rdata. Select lane by addr[1:0]: byte lanes 0..3 = bits [7:0]..[31:24]; halfword lanes 0/2. Extend to 32 bits. → RESP.
- RMW_RD: capture mem_rdata, replace the addressed byte/halfword lane with req_wdata's low bits, load the result into mem_wdata. → WR.
- WR: mem_wr_en = 1 for exactly this cycle. → RESP.
- RESP: resp_valid = 1 for one cycle with resp_rdata and resp_err. → IDLE.
- Errors:
  - req_size = 11 always gives resp_err = 1.
  - Misalignment handling depends on the configuration macro.
- Address wrap: bits above IDX_W+1 are ignored, so byte address 0x1000 aliases word 0.
- mem_addr and mem_wdata hold their last values outside active states; mem_wr_en is 0 outside WR.

## Timing
- Reset values: state IDLE, req_ready 0 while rst_n is low, then 1 from the first cycle after release. resp_valid 0, resp_rdata 0, resp_err 0, mem_wr_en 0, mem_addr 0, mem_wdata 0.
- Acceptance at edge T (req_valid & req_ready). resp_valid is high in the cycle after:
  - load: T+2;
  - word store: T+2, with mem_wr_en in cycle T+1;
  - sub-word store: T+3, with mem_wr_en in cycle T+2;
  - error: T+1.
- Next acceptance is possible at the edge ending the RESP cycle + 1, i.e. req_ready is high again the cycle after resp_valid. No back-to-back overlap.
- req_valid while busy: ignored; the pipeline stalls on !req_ready.
- Reset mid-operation: the next edge with rst_n low forces IDLE and zeroes all outputs. An RMW in RMW_RD does not write. A WR-cycle write that coincides with that edge is still committed by memory; that is accepted behaviour.

## Configuration
- MEM_MISALIGN_TRAP_EN defined: halfword with addr[0] = 1, or word with addr[1:0] ≠ 0, completes as an error (resp_err = 1, no memory access, RESP at T+1).
- Not defined: low address bits are forced to alignment (half: addr[0] = 0; word: addr[1:0] = 00). The access proceeds normally and resp_err is set only for size 11.

## Test plan
- Reset: hold rst_n low for 3 cycles with req_valid = 1 → req_ready/resp_valid/mem_wr_en stay 0; req_ready = 1 on the first cycle after release.
- Word store then load: store 0xDEADBEEF at 0x10 → mem_wr_en at T+1 with mem_addr = 4; load word 0x10 → resp_rdata = 0xDEADBEEF at T+2.
- Byte RMW: word 4 = 0x11223344; store byte 0xAB at 0x12 → memory word becomes 0x11AB3344, resp at T+3.
- Signed/unsigned loads from 0x11AB3344 at word 4:
  - lb 0x12 → 0xFFFFFFAB;
  - lbu 0x12 → 0x000000AB;
  - lh 0x10 → 0x00003344.
- Misaligned: word load at 0x13 → with macro, resp_err = 1 at T+1 and no mem_wr_en; without macro, returns word 4.
- Reset during RMW: assert rst_n low in the RMW_RD cycle → no mem_wr_en, memory word unchanged, IDLE afterward; req_size = 11 → resp_err = 1.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator: word-addressed data memory port, read-modify-write sub-word stores.
// Optional macro MEM_MISALIGN_TRAP_EN: misaligned half/word accesses complete as errors instead of being aligned.
module mem_access_unit #(
  parameter int DEPTH_WORDS = 1024,
  localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_wr_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RMW_RD,
    S_WR,
    S_RESP
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  state_t      state;
  state_t      state_nxt;

  logic [1:0]  size_q;
  logic        signed_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;

  logic        accept;
  logic        req_err;
  logic [1:0]  req_off;

  // Address bits above the word index alias onto the same memory word.
  logic        unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:IDX_W+2];

  // Little-endian lane extraction with optional sign extension.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  off,
                                              input logic        sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: res = {{24{sgn & b[7]}}, b};
      SZ_HALF: res = {{16{sgn & h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Replace the addressed lane of the old word with the low bits of the store data.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  size,
                                              input logic [1:0]  off);
    logic [31:0] res;
    res = word;
    case (size)
      SZ_BYTE: res[{off, 3'b000} +: 8] = wdata[7:0];
      SZ_HALF: begin
        if (off[1]) res[31:16] = wdata[15:0];
        else        res[15:0]  = wdata[15:0];
      end
      default: res = wdata;
    endcase
    return res;
  endfunction

`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign;
  assign misalign = ((req_size == SZ_HALF) && req_addr[0]) ||
                    ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
  assign req_err  = (req_size == SZ_RSVD) || misalign;
  assign req_off  = req_addr[1:0];
`else
  assign req_err  = (req_size == SZ_RSVD);
  always_comb begin
    case (req_size)
      SZ_HALF: req_off = {req_addr[1], 1'b0};
      SZ_WORD: req_off = 2'b00;
      default: req_off = req_addr[1:0];
    endcase
  end
`endif

  assign accept = req_valid && req_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block is defaulted first, so no path leaves one unassigned (no latches).
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_wr_en  = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = rst_n;
        if (accept) begin
          if (req_err)                 state_nxt = S_RESP;
          else if (!req_we)            state_nxt = S_RD;
          else if (req_size == SZ_WORD) state_nxt = S_WR;
          else                         state_nxt = S_RMW_RD;
        end
      end
      S_RD:     state_nxt = S_RESP;
      S_RMW_RD: state_nxt = S_WR;
      S_WR: begin
        mem_wr_en = 1'b1;
        state_nxt = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: datapath registers are reset too, because they drive ports whose reset value is visible.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      size_q     <= '0;
      signed_q   <= 1'b0;
      off_q      <= '0;
      wdata_q    <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            size_q     <= req_size;
            signed_q   <= req_signed;
            off_q      <= req_off;
            wdata_q    <= req_wdata;
            mem_addr   <= {{(32-IDX_W){1'b0}}, req_addr[IDX_W+1:2]};
            resp_rdata <= '0;
            resp_err   <= req_err;
            if (!req_err && req_we && (req_size == SZ_WORD)) mem_wdata <= req_wdata;
          end
        end
        S_RD:     resp_rdata <= load_extend(mem_rdata, size_q, off_q, signed_q);
        S_RMW_RD: mem_wdata  <= store_merge(mem_rdata, wdata_q, size_q, off_q);
        S_RESP: begin
          resp_rdata <= '0;
          resp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
